// File: rtl/unidad_cortocircuito.sv
`default_nettype none
// ============================================================================
//  Module   : unidad_cortocircuito
//  Purpose  : Forwarding and load-use hazard unit for the 5-stage MIPS
//             pipeline. It keeps a shadow copy of the destination register,
//             write-enable and load flag of the instructions in EX and MEM.
//             From that copy it produces registered forwarding selects for
//             ALU operands A (rs) and B (rt). It also raises a one-cycle
//             stall on a load-use hazard and puts a bubble into its own
//             shadow pipeline.
//  Ports    : i_clk, i_reset (sync, active-high), i_step (advance enable),
//             i_flush (squash ID), i_id_* (ID-stage operand and destination
//             info), o_corto_register_A/B (001 = EX/MEM, 010 = MEM/WB,
//             000 = ID/EX), o_stall (combinational), o_stall_count (bubbles
//             inserted since reset).
//  Revision : 1.0 - initial release
// ============================================================================
module unidad_cortocircuito #(
   parameter int BITS_REGS          = 5,
   parameter int BITS_CORTOCIRCUITO = 3,
   parameter int BITS_COUNT         = 32
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_step,
   input  logic                          i_flush,
   input  logic [BITS_REGS-1:0]          i_id_rs,
   input  logic [BITS_REGS-1:0]          i_id_rt,
   input  logic                          i_id_uses_rs,
   input  logic                          i_id_uses_rt,
   input  logic [BITS_REGS-1:0]          i_id_rd,
   input  logic                          i_id_regwrite,
   input  logic                          i_id_memread,
   output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A,
   output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B,
   output logic                          o_stall,
   output logic [BITS_COUNT-1:0]         o_stall_count
);

   localparam logic [BITS_CORTOCIRCUITO-1:0] c_sel_idex  = BITS_CORTOCIRCUITO'(0);
   localparam logic [BITS_CORTOCIRCUITO-1:0] c_sel_exmem = BITS_CORTOCIRCUITO'(1);
   localparam logic [BITS_CORTOCIRCUITO-1:0] c_sel_memwb = BITS_CORTOCIRCUITO'(2);
   localparam logic [BITS_REGS-1:0]          c_reg_zero  = '0;
   localparam logic [BITS_COUNT-1:0]         c_count_one = BITS_COUNT'(1);

   // Shadow pipeline state
   logic [BITS_REGS-1:0]          ex_rd_q,  ex_rd_d;
   logic                          ex_regwrite_q, ex_regwrite_d;
   logic                          ex_memread_q,  ex_memread_d;
   logic [BITS_REGS-1:0]          mem_rd_q, mem_rd_d;
   logic                          mem_regwrite_q, mem_regwrite_d;
   logic [BITS_CORTOCIRCUITO-1:0] sel_a_q, sel_a_d;
   logic [BITS_CORTOCIRCUITO-1:0] sel_b_q, sel_b_d;
   logic [BITS_COUNT-1:0]         count_q, count_d;

   logic [BITS_CORTOCIRCUITO-1:0] w_sel_a;
   logic [BITS_CORTOCIRCUITO-1:0] w_sel_b;
   logic                          w_hazard;

   // Forwarding select for one operand. EX is checked first so the youngest
   // producer wins when both EX and MEM write the same register.
   function automatic logic [BITS_CORTOCIRCUITO-1:0] f_sel(
      input logic                 uses,
      input logic [BITS_REGS-1:0] src,
      input logic [BITS_REGS-1:0] ex_rd,
      input logic                 ex_we,
      input logic [BITS_REGS-1:0] mem_rd,
      input logic                 mem_we
   );
      f_sel = c_sel_idex;
      if (uses && ex_we && (ex_rd != c_reg_zero) && (ex_rd == src)) begin
         f_sel = c_sel_exmem;
      end else if (uses && mem_we && (mem_rd != c_reg_zero) && (mem_rd == src)) begin
         f_sel = c_sel_memwb;
      end
   endfunction

   always_comb begin
      w_sel_a  = f_sel(i_id_uses_rs, i_id_rs, ex_rd_q, ex_regwrite_q, mem_rd_q, mem_regwrite_q);
      w_sel_b  = f_sel(i_id_uses_rt, i_id_rt, ex_rd_q, ex_regwrite_q, mem_rd_q, mem_regwrite_q);
      // A load still in EX cannot be forwarded yet; its consumer waits a cycle
      w_hazard = ex_memread_q && (ex_rd_q != c_reg_zero) &&
                 ((i_id_uses_rs && (ex_rd_q == i_id_rs)) ||
                  (i_id_uses_rt && (ex_rd_q == i_id_rt)));
   end

   assign o_stall = w_hazard && i_step && !i_flush;

   always_comb begin
      ex_rd_d        = ex_rd_q;
      ex_regwrite_d  = ex_regwrite_q;
      ex_memread_d   = ex_memread_q;
      mem_rd_d       = mem_rd_q;
      mem_regwrite_d = mem_regwrite_q;
      sel_a_d        = sel_a_q;
      sel_b_d        = sel_b_q;
      count_d        = count_q;
      if (i_step) begin
         mem_rd_d       = ex_rd_q;
         mem_regwrite_d = ex_regwrite_q;
         if (i_flush || w_hazard) begin
            // Bubble: the ID instruction does not enter EX this cycle
            ex_rd_d       = c_reg_zero;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            sel_a_d       = c_sel_idex;
            sel_b_d       = c_sel_idex;
            if (!i_flush) begin
               count_d = count_q + c_count_one;
            end
         end else begin
            ex_rd_d       = i_id_rd;
            ex_regwrite_d = i_id_regwrite;
            ex_memread_d  = i_id_memread;
            sel_a_d       = w_sel_a;
            sel_b_d       = w_sel_b;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ex_rd_q        <= c_reg_zero;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         mem_rd_q       <= c_reg_zero;
         mem_regwrite_q <= 1'b0;
         sel_a_q        <= c_sel_idex;
         sel_b_q        <= c_sel_idex;
         count_q        <= '0;
      end else begin
         ex_rd_q        <= ex_rd_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_memread_q   <= ex_memread_d;
         mem_rd_q       <= mem_rd_d;
         mem_regwrite_q <= mem_regwrite_d;
         sel_a_q        <= sel_a_d;
         sel_b_q        <= sel_b_d;
         count_q        <= count_d;
      end
   end

   assign o_corto_register_A = sel_a_q;
   assign o_corto_register_B = sel_b_q;
   assign o_stall_count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_unidad_cortocircuito.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unidad_cortocircuito
//  Purpose  : Self-checking bench for unidad_cortocircuito. A queue-based
//             model of the instructions in EX and MEM predicts the selects,
//             stall and stall count each cycle; directed sequences pin the
//             model with literal expectations, then random traffic follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unidad_cortocircuito;

   logic       clk = 1'b0;
   logic       i_reset, i_step, i_flush;
   logic [4:0] i_id_rs, i_id_rt, i_id_rd;
   logic       i_id_uses_rs, i_id_uses_rt, i_id_regwrite, i_id_memread;
   logic [2:0] o_corto_register_A, o_corto_register_B;
   logic       o_stall;
   logic [31:0] o_stall_count;

   always #5 clk = ~clk;

   unidad_cortocircuito dut (
      .i_clk              (clk),
      .i_reset            (i_reset),
      .i_step             (i_step),
      .i_flush            (i_flush),
      .i_id_rs            (i_id_rs),
      .i_id_rt            (i_id_rt),
      .i_id_uses_rs       (i_id_uses_rs),
      .i_id_uses_rt       (i_id_uses_rt),
      .i_id_rd            (i_id_rd),
      .i_id_regwrite      (i_id_regwrite),
      .i_id_memread       (i_id_memread),
      .o_corto_register_A (o_corto_register_A),
      .o_corto_register_B (o_corto_register_B),
      .o_stall            (o_stall),
      .o_stall_count      (o_stall_count)
   );

   typedef struct packed {
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } slot_t;

   // shadow[0] = instruction in EX, shadow[1] = instruction in MEM
   slot_t       shadow[$];
   logic [2:0]  exp_sel_a, exp_sel_b;
   logic [31:0] exp_count;
   logic        last_stall;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [2:0] m_sel(input logic uses, input logic [4:0] r);
      logic [2:0] s;
      s = 3'b000;
      if (uses && r != 5'd0) begin
         // older producer first; younger overwrites
         for (int k = 1; k >= 0; k--)
            if (shadow[k].rw && shadow[k].rd == r) s = (k == 0) ? 3'b001 : 3'b010;
      end
      return s;
   endfunction

   function automatic logic m_hazard();
      return shadow[0].mr && shadow[0].rd != 5'd0 &&
             ((i_id_uses_rs && shadow[0].rd == i_id_rs) ||
              (i_id_uses_rt && shadow[0].rd == i_id_rt));
   endfunction

   task automatic model_clear();
      shadow.delete();
      shadow.push_back('0);
      shadow.push_back('0);
      exp_sel_a = 3'b000;
      exp_sel_b = 3'b000;
      exp_count = 32'd0;
   endtask

   // One pipeline cycle: drive ID inputs, check all outputs, clock, update model
   task automatic cycle(input int rs, input int rt, input int urs, input int urt,
                        input int rd, input int rw, input int mr,
                        input int step, input int flush, input int rst);
      logic        hz, exp_stall;
      slot_t       nxt;
      logic [2:0]  na, nb;
      @(negedge clk);
      i_id_rs = 5'(rs);  i_id_rt = 5'(rt);
      i_id_uses_rs = 1'(urs); i_id_uses_rt = 1'(urt);
      i_id_rd = 5'(rd);  i_id_regwrite = 1'(rw); i_id_memread = 1'(mr);
      i_step = 1'(step); i_flush = 1'(flush); i_reset = 1'(rst);
      #1;
      hz = m_hazard();
      exp_stall = hz && i_step && !i_flush;
      chk("stall", 32'(o_stall), 32'(exp_stall));
      chk("sel_a", 32'(o_corto_register_A), 32'(exp_sel_a));
      chk("sel_b", 32'(o_corto_register_B), 32'(exp_sel_b));
      chk("count", o_stall_count, exp_count);
      last_stall = o_stall;
      na = m_sel(i_id_uses_rs, i_id_rs);
      nb = m_sel(i_id_uses_rt, i_id_rt);
      @(posedge clk);
      if (i_reset) begin
         model_clear();
      end else if (i_step) begin
         if (i_flush || hz) begin
            nxt = '0;
            exp_sel_a = 3'b000;
            exp_sel_b = 3'b000;
            if (!i_flush) exp_count = exp_count + 32'd1;
         end else begin
            nxt = '{rd: i_id_rd, rw: i_id_regwrite, mr: i_id_memread};
            exp_sel_a = na;
            exp_sel_b = nb;
         end
         shadow.push_front(nxt);
         void'(shadow.pop_back());
      end
      #1;
   endtask

   // shorthands: (rs, rt, urs, urt, rd, rw, mr, step, flush, rst)
   task automatic rst_cycle();
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
   endtask

   initial begin
      i_reset = 1'b1; i_step = 1'b0; i_flush = 1'b0;
      i_id_rs = '0; i_id_rt = '0; i_id_rd = '0;
      i_id_uses_rs = 1'b0; i_id_uses_rt = 1'b0;
      i_id_regwrite = 1'b0; i_id_memread = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_sel_a", 32'(o_corto_register_A), 32'd0);
      chk("reset_sel_b", 32'(o_corto_register_B), 32'd0);
      chk("reset_stall", 32'(o_stall), 32'd0);
      chk("reset_count", o_stall_count, 32'd0);

      // Forward from EX/MEM
      rst_cycle();
      cycle(1, 2, 1, 1, 3, 1, 0, 1, 0, 0);   // add $3
      cycle(3, 1, 1, 1, 8, 1, 0, 1, 0, 0);   // sub rs=3
      chk("fwd_ex_a", 32'(o_corto_register_A), 32'd1);
      chk("fwd_ex_b", 32'(o_corto_register_B), 32'd0);

      // Forward from MEM/WB, then EX beats MEM
      rst_cycle();
      cycle(1, 2, 1, 1, 4, 1, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cycle(9, 4, 0, 1, 10, 0, 0, 1, 0, 0);
      chk("fwd_mem_b", 32'(o_corto_register_B), 32'd2);
      cycle(1, 2, 1, 1, 4, 1, 0, 1, 0, 0);
      cycle(1, 2, 0, 0, 4, 1, 0, 1, 0, 0);
      cycle(9, 4, 0, 1, 10, 0, 0, 1, 0, 0);
      chk("fwd_both_b", 32'(o_corto_register_B), 32'd1);

      // Load-use
      rst_cycle();
      cycle(1, 0, 1, 0, 5, 1, 1, 1, 0, 0);   // lw $5
      cycle(5, 6, 1, 1, 7, 1, 0, 1, 0, 0);   // add rs=5 -> stall
      chk("lu_stall", 32'(last_stall), 32'd1);
      chk("lu_count", o_stall_count, 32'd1);
      cycle(5, 6, 1, 1, 7, 1, 0, 1, 0, 0);   // held add enters EX
      chk("lu_nostall", 32'(last_stall), 32'd0);
      chk("lu_sel_a", 32'(o_corto_register_A), 32'd2);
      chk("lu_count2", o_stall_count, 32'd1);

      // Register 0 never forwards or stalls
      rst_cycle();
      cycle(1, 2, 1, 1, 0, 1, 1, 1, 0, 0);
      cycle(0, 0, 1, 1, 3, 1, 0, 1, 0, 0);
      chk("r0_stall", 32'(last_stall), 32'd0);
      chk("r0_sel_a", 32'(o_corto_register_A), 32'd0);
      chk("r0_sel_b", 32'(o_corto_register_B), 32'd0);

      // Flush beats hazard
      rst_cycle();
      cycle(1, 2, 1, 1, 6, 1, 1, 1, 0, 0);
      cycle(6, 2, 1, 1, 3, 1, 0, 1, 1, 0);
      chk("fl_stall", 32'(last_stall), 32'd0);
      chk("fl_count", o_stall_count, 32'd0);
      chk("fl_sel_a", 32'(o_corto_register_A), 32'd0);

      // Step low during hazard freezes everything
      rst_cycle();
      cycle(1, 2, 1, 1, 7, 1, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(2, 7, 1, 1, 3, 1, 0, 0, 0, 0);
         chk("st_stall", 32'(last_stall), 32'd0);
         chk("st_count", o_stall_count, 32'd0);
      end
      cycle(2, 7, 1, 1, 3, 1, 0, 1, 0, 0);
      chk("st_resume_stall", 32'(last_stall), 32'd1);
      chk("st_resume_count", o_stall_count, 32'd1);

      // Reset during a stall cycle
      cycle(1, 2, 1, 1, 5, 1, 1, 1, 0, 0);
      cycle(5, 2, 1, 1, 3, 1, 0, 1, 0, 1);
      chk("rs_count", o_stall_count, 32'd0);
      chk("rs_sel_a", 32'(o_corto_register_A), 32'd0);
      chk("rs_sel_b", 32'(o_corto_register_B), 32'd0);
      cycle(5, 2, 1, 1, 3, 1, 0, 1, 0, 0);
      chk("rs_nostall", 32'(last_stall), 32'd0);

      // Random traffic over a small register set
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 9) != 0) ? 1 : 0,
               ($urandom_range(0, 9) == 0) ? 1 : 0,
               ($urandom_range(0, 49) == 0) ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
